alu_share_arbiter: RTL and testbench

- Shares one `alu` datapath instance between two requesters, e.g. the main execute stage (port 0) and an address/branch helper (port 1).
- Per-port valid/ready request and response handshakes; round-robin arbitration; 3-state FSM sequences a single operation at a time.
- Operands and control are registered before driving the ALU; results and flags are registered and held until the owning port accepts them.

---
 rtl/alu_share_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Two-port round-robin front end sharing one registered ALU datapath.
// Define ALU_ARB_OPCHECK_EN to add rsp_err and force a zero result on unknown control codes.
`ifndef ALU_CONTROL_ADD
`define ALU_CONTROL_ADD 6'h01
`endif
`ifndef ALU_CONTROL_SUB
`define ALU_CONTROL_SUB 6'h02
`endif
`ifndef ALU_CONTROL_AND
`define ALU_CONTROL_AND 6'h03
`endif
`ifndef ALU_CONTROL_OR
`define ALU_CONTROL_OR 6'h04
`endif
`ifndef ALU_CONTROL_XOR
`define ALU_CONTROL_XOR 6'h05
`endif

module alu_share_arbiter #(
  parameter int unsigned RESET_PRIORITY = 0,
  parameter int unsigned CTRL_W         = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_0,
  input  logic              req_valid_1,
  output logic              req_ready_0,
  output logic              req_ready_1,
  input  logic [31:0]       req_a_0,
  input  logic [31:0]       req_a_1,
  input  logic [31:0]       req_b_0,
  input  logic [31:0]       req_b_1,
  input  logic [CTRL_W-1:0] req_ctrl_0,
  input  logic [CTRL_W-1:0] req_ctrl_1,
  output logic              rsp_valid_0,
  output logic              rsp_valid_1,
  input  logic              rsp_ready_0,
  input  logic              rsp_ready_1,
  output logic [31:0]       rsp_result,
  output logic              rsp_zero,
  output logic              rsp_equal,
`ifdef ALU_ARB_OPCHECK_EN
  output logic              rsp_err,
`endif
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e            state_q, state_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic              owner_q, owner_d;
  logic [31:0]       a_q, a_d, b_q, b_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [31:0]       result_q, result_d;
  logic              zero_q, zero_d;
  logic              equal_q, equal_d;
  logic [1:0]        rsp_valid_q, rsp_valid_d;

  logic              any_valid, grant;
  logic [31:0]       alu_result, res_sel;

  assign any_valid   = req_valid_0 | req_valid_1;
  // With both requesting the pointer decides; otherwise the lone requester wins.
  assign grant       = (req_valid_0 & req_valid_1) ? rr_ptr_q : req_valid_1;
  assign req_ready_0 = (state_q == StIdle) & any_valid & ~grant;
  assign req_ready_1 = (state_q == StIdle) & any_valid & grant;

  // Shared ALU datapath; unknown codes yield zero.
  always_comb begin
    alu_result = '0;
    case (ctrl_q)
      `ALU_CONTROL_ADD: alu_result = a_q + b_q;
      `ALU_CONTROL_SUB: alu_result = a_q - b_q;
      `ALU_CONTROL_AND: alu_result = a_q & b_q;
      `ALU_CONTROL_OR:  alu_result = a_q | b_q;
      `ALU_CONTROL_XOR: alu_result = a_q ^ b_q;
      default:          alu_result = '0;
    endcase
  end

`ifdef ALU_ARB_OPCHECK_EN
  logic ctrl_legal;
  logic err_q, err_d;
  assign ctrl_legal = ctrl_q inside {`ALU_CONTROL_ADD, `ALU_CONTROL_SUB, `ALU_CONTROL_AND,
                                     `ALU_CONTROL_OR, `ALU_CONTROL_XOR};
  assign res_sel    = ctrl_legal ? alu_result : '0;
`else
  assign res_sel    = alu_result;
`endif

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    a_d         = a_q;
    b_d         = b_q;
    ctrl_d      = ctrl_q;
    result_d    = result_q;
    zero_d      = zero_q;
    equal_d     = equal_q;
    rsp_valid_d = rsp_valid_q;
`ifdef ALU_ARB_OPCHECK_EN
    err_d       = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (any_valid) begin
          owner_d = grant;
          a_d     = grant ? req_a_1 : req_a_0;
          b_d     = grant ? req_b_1 : req_b_0;
          ctrl_d  = grant ? req_ctrl_1 : req_ctrl_0;
          state_d = StExec;
        end
      end
      StExec: begin
        result_d             = res_sel;
        zero_d               = (res_sel == '0);
        equal_d              = (a_q == b_q);
        rsp_valid_d[owner_q] = 1'b1;
`ifdef ALU_ARB_OPCHECK_EN
        err_d                = ~ctrl_legal;
`endif
        state_d              = StResp;
      end
      StResp: begin
        // Pointer moves only on completion, so back-to-back pairs strictly alternate.
        if (owner_q ? rsp_ready_1 : rsp_ready_0) begin
          rsp_valid_d = '0;
          rr_ptr_d    = ~owner_q;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rr_ptr_q    <= 1'(RESET_PRIORITY);
      owner_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      ctrl_q      <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      equal_q     <= 1'b0;
      rsp_valid_q <= '0;
`ifdef ALU_ARB_OPCHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      a_q         <= a_d;
      b_q         <= b_d;
      ctrl_q      <= ctrl_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      equal_q     <= equal_d;
      rsp_valid_q <= rsp_valid_d;
`ifdef ALU_ARB_OPCHECK_EN
      err_q       <= err_d;
`endif
    end
  end

  assign rsp_valid_0 = rsp_valid_q[0];
  assign rsp_valid_1 = rsp_valid_q[1];
  assign rsp_result  = result_q;
  assign rsp_zero    = zero_q;
  assign rsp_equal   = equal_q;
  assign busy        = (state_q != StIdle);
`ifdef ALU_ARB_OPCHECK_EN
  assign rsp_err     = err_q;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: expected responses are queued at request handshake
// and compared when the owning port sees rsp_valid.
module tb_alu_share_arbiter;

  localparam logic [5:0] CtrlAdd = 6'h01;
  localparam logic [5:0] CtrlSub = 6'h02;
  localparam logic [5:0] CtrlAnd = 6'h03;
  localparam logic [5:0] CtrlOr  = 6'h04;
  localparam logic [5:0] CtrlXor = 6'h05;

  typedef struct {
    bit          port;
    logic [31:0] result;
    bit          zero;
    bit          equal;
    bit          err;
    int unsigned hs_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid [2];
  logic        req_ready [2];
  logic [31:0] req_a [2];
  logic [31:0] req_b [2];
  logic [5:0]  req_ctrl [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_result;
  logic        rsp_zero, rsp_equal, busy;
`ifdef ALU_ARB_OPCHECK_EN
  logic        rsp_err;
`endif

  exp_t        sb_q [$];
  bit          grant_log [$];
  bit          front_seen = 1'b0;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_bad = 0;
  logic [5:0]  ctrl_tab [5];

  alu_share_arbiter #(.RESET_PRIORITY(0), .CTRL_W(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid_0(req_valid[0]),
    .req_valid_1(req_valid[1]),
    .req_ready_0(req_ready[0]),
    .req_ready_1(req_ready[1]),
    .req_a_0    (req_a[0]),
    .req_a_1    (req_a[1]),
    .req_b_0    (req_b[0]),
    .req_b_1    (req_b[1]),
    .req_ctrl_0 (req_ctrl[0]),
    .req_ctrl_1 (req_ctrl[1]),
    .rsp_valid_0(rsp_valid[0]),
    .rsp_valid_1(rsp_valid[1]),
    .rsp_ready_0(rsp_ready[0]),
    .rsp_ready_1(rsp_ready[1]),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_equal  (rsp_equal),
`ifdef ALU_ARB_OPCHECK_EN
    .rsp_err    (rsp_err),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input bit port, input logic [5:0] ctrl, input logic [31:0] a,
                                 input logic [31:0] b, input int unsigned c);
    exp_t e;
    e.port   = port;
    e.err    = 1'b0;
    e.result = '0;
    e.hs_cyc = c;
    case (ctrl)
      CtrlAdd: e.result = a + b;
      CtrlSub: e.result = a - b;
      CtrlAnd: e.result = a & b;
      CtrlOr:  e.result = a | b;
      CtrlXor: e.result = a ^ b;
      default: e.err = 1'b1;
    endcase
    e.zero  = (e.result == 32'h0);
    e.equal = (a == b);
    return e;
  endfunction

  // Monitor: push on request handshake, compare every cycle a response is shown.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      grant_log.delete();
      front_seen = 1'b0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (req_valid[p] && req_ready[p]) begin
          sb_q.push_back(model(1'(p), req_ctrl[p], req_a[p], req_b[p], cyc));
          grant_log.push_back(1'(p));
        end
      end
      if (rsp_valid[0] || rsp_valid[1]) begin
        if (sb_q.size() == 0) begin
          check_eq("rsp_unexpected", 32'(1), 32'(0));
        end else begin
          exp_t e;
          e = sb_q[0];
          check_eq("rsp_owner", 32'({rsp_valid[1], rsp_valid[0]}),
                   e.port ? 32'(2) : 32'(1));
          if (!front_seen) begin
            check_eq("latency", cyc - e.hs_cyc, 32'(2));
            front_seen = 1'b1;
          end
          check_eq("result", rsp_result, e.result);
          check_eq("zero", 32'(rsp_zero), 32'(e.zero));
          check_eq("equal", 32'(rsp_equal), 32'(e.equal));
`ifdef ALU_ARB_OPCHECK_EN
          check_eq("err", 32'(rsp_err), 32'(e.err));
`endif
          if (rsp_ready[e.port]) begin
            void'(sb_q.pop_front());
            front_seen = 1'b0;
          end
        end
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after the edge that completed the handshake.
  task automatic send(input int p, input logic [5:0] ctrl, input logic [31:0] a,
                      input logic [31:0] b);
    bit done = 1'b0;
    req_valid[p] = 1'b1;
    req_a[p]     = a;
    req_b[p]     = b;
    req_ctrl[p]  = ctrl;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (req_ready[p]) done = 1'b1;
      @(posedge clk);
      #1;
    end
    req_valid[p] = 1'b0;
    if (!done) check_eq("req_timeout", 32'(0), 32'(1));
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !busy) ok = 1'b1;
    end
    if (!ok) check_eq("drain_timeout", 32'(0), 32'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(input int p);
    bit seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (rsp_valid[p]) seen = 1'b1;
      else check_eq("wait_ready1_low", 32'(req_ready[1]), 32'(p == 0 ? 0 : req_ready[1]));
    end
    if (!seen) check_eq("rsp_timeout", 32'(0), 32'(1));
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    ctrl_tab = '{CtrlAdd, CtrlSub, CtrlAnd, CtrlOr, CtrlXor};
    for (int p = 0; p < 2; p++) begin
      req_valid[p] = 1'b0;
      req_a[p]     = '0;
      req_b[p]     = '0;
      req_ctrl[p]  = '0;
      rsp_ready[p] = 1'b1;
    end

    // Reset state
    #1;
    check_eq("rst_rsp_valid0", 32'(rsp_valid[0]), 32'(0));
    check_eq("rst_rsp_valid1", 32'(rsp_valid[1]), 32'(0));
    check_eq("rst_result", rsp_result, 32'h0);
    check_eq("rst_zero", 32'(rsp_zero), 32'(0));
    check_eq("rst_equal", 32'(rsp_equal), 32'(0));
    check_eq("rst_busy", 32'(busy), 32'(0));
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single port-0 ADD
    send(0, CtrlAdd, 32'd5, 32'd7);
    wait_done();

    // Simultaneous requests, four back-to-back pairs must alternate starting at port 0
    apply_reset();
    fork
      begin
        send(0, CtrlSub, 32'd9, 32'd9);
        for (int i = 0; i < 3; i++) send(0, ctrl_tab[$urandom_range(4)], $urandom(), $urandom());
      end
      begin
        send(1, CtrlXor, 32'hFF, 32'h0F);
        for (int i = 0; i < 3; i++) send(1, ctrl_tab[$urandom_range(4)], $urandom(), $urandom());
      end
    join
    wait_done();
    check_eq("grant_count", 32'(grant_log.size()), 32'(8));
    for (int i = 0; i < 8 && i < grant_log.size(); i++)
      check_eq($sformatf("grant%0d", i), 32'(grant_log[i]), 32'(i % 2));

    // Port 0 response stalled while port 1 waits
    rsp_ready[0] = 1'b0;
    send(0, CtrlAnd, 32'hF0F0F0F0, 32'h0FF00FF0);
    req_valid[1] = 1'b1;
    req_a[1]     = 32'd3;
    req_b[1]     = 32'd4;
    req_ctrl[1]  = CtrlOr;
    wait_rsp(0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("stall_valid0", 32'(rsp_valid[0]), 32'(1));
      check_eq("stall_ready1", 32'(req_ready[1]), 32'(0));
      check_eq("stall_result", rsp_result, 32'h00F000F0);
    end
    @(posedge clk);
    #1;
    rsp_ready[0] = 1'b1;
    send(1, CtrlOr, 32'd3, 32'd4);
    wait_done();

    // Wrap-around and unknown control code
    send(0, CtrlAdd, 32'hFFFFFFFF, 32'd1);
    wait_done();
    send(1, CtrlSub, 32'd0, 32'd1);
    wait_done();
    send(0, 6'h3F, 32'd3, 32'd4);
    wait_done();

    // Reset while port 1 holds a response; pointer must return to port 0
    send(0, CtrlAdd, 32'd1, 32'd2);
    wait_done();
    rsp_ready[1] = 1'b0;
    send(1, CtrlXor, 32'd5, 32'd5);
    wait_rsp(1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_rsp_valid0", 32'(rsp_valid[0]), 32'(0));
    check_eq("arst_rsp_valid1", 32'(rsp_valid[1]), 32'(0));
    check_eq("arst_req_ready0", 32'(req_ready[0]), 32'(0));
    check_eq("arst_req_ready1", 32'(req_ready[1]), 32'(0));
    check_eq("arst_result", rsp_result, 32'h0);
    check_eq("arst_zero", 32'(rsp_zero), 32'(0));
    check_eq("arst_equal", 32'(rsp_equal), 32'(0));
    check_eq("arst_busy", 32'(busy), 32'(0));
`ifdef ALU_ARB_OPCHECK_EN
    check_eq("arst_err", 32'(rsp_err), 32'(0));
`endif
    @(negedge clk);
    #1 rst_n = 1'b1;
    rsp_ready[1] = 1'b1;
    @(posedge clk);
    #1;
    fork
      send(0, CtrlAdd, 32'd10, 32'd20);
      send(1, CtrlAdd, 32'd30, 32'd40);
    join
    wait_done();
    check_eq("post_rst_count", 32'(grant_log.size()), 32'(2));
    if (grant_log.size() > 0) check_eq("post_rst_grant", 32'(grant_log[0]), 32'(0));

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
